spi_register_bank: RTL

SPI mode-0 target that receives register frames from an external controller and holds the five control registers consumed by pwm_peripheral. These are the output-enable, PWM-enable and duty-cycle registers. It sits directly upstream of pwm_peripheral inside tt_um_uwasic_onboarding_joanna, with its SPI pins taken from ui_in. Adds synchronised inputs, framing error detection, an explicit commit stage and register read-back on CIPO.

---
 rtl/spi_register_bank.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/spi_register_bank.sv
// SPI mode-0 target holding the pwm_peripheral control registers.
// 16-bit frames {rw, addr[6:0], data[7:0]}; writes commit on ncs rise, reads shift out on cipo.
module spi_register_bank #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_REGS    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       frame_valid,
  output logic       frame_err
);

  localparam int unsigned NR_STORE = (NUM_REGS > 5) ? NUM_REGS : 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_COMMIT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_copi_sync;
  logic [SYNC_STAGES-1:0] r_ncs_sync;
  logic [SYNC_STAGES-1:0] r_ncs_vld;
  logic                   r_sclk_d;
  logic                   r_ncs_d;
  logic                   r_ncs_armed;

  logic w_sclk;
  logic w_copi;
  logic w_ncs;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_ncs_rise;
  logic w_ncs_fall;

  logic [15:0] r_shift;
  logic [4:0]  r_cnt;
  logic [7:0]  r_tx;
  logic        r_rd_active;
  logic        r_cipo;
  logic        r_frame_valid;
  logic        r_frame_err;
  logic [7:0]  r_regs [NR_STORE];

  logic [15:0] w_shift_nxt;
  logic [7:0]  w_rd_data;

  // r_ncs_vld tracks how far real pin samples have propagated since reset, so the
  // reset value of the ncs synchroniser can never arm a falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_copi_sync <= '0;
      r_ncs_sync  <= '1;
      r_ncs_vld   <= '0;
      r_sclk_d    <= 1'b0;
      r_ncs_d     <= 1'b1;
      r_ncs_armed <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
      r_ncs_vld   <= {r_ncs_vld[SYNC_STAGES-2:0], 1'b1};
      r_sclk_d    <= w_sclk;
      r_ncs_d     <= w_ncs;
      if (r_ncs_vld[SYNC_STAGES-1] && w_ncs) begin
        r_ncs_armed <= 1'b1;
      end
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_copi      = r_copi_sync[SYNC_STAGES-1];
  assign w_ncs       = r_ncs_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_ncs_rise  = w_ncs & ~r_ncs_d;
  assign w_ncs_fall  = r_ncs_armed & ~w_ncs & r_ncs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_ncs_fall) w_state_nxt = S_SHIFT;
      S_SHIFT:  if (w_ncs_rise) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign w_shift_nxt = {r_shift[14:0], w_copi};

  // Read address is taken from the header byte as it completes on the 8th rising edge.
  always_comb begin
    w_rd_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (w_shift_nxt[6:0] == 7'(i)) begin
        w_rd_data = r_regs[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift       <= '0;
      r_cnt         <= '0;
      r_tx          <= '0;
      r_rd_active   <= 1'b0;
      r_cipo        <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      for (int unsigned i = 0; i < NR_STORE; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cipo      <= 1'b0;
          r_rd_active <= 1'b0;
          if (w_ncs_fall) begin
            r_cnt   <= '0;
            r_shift <= '0;
          end
        end
        S_SHIFT: begin
          if (w_ncs) begin
            r_cipo      <= 1'b0;
            r_rd_active <= 1'b0;
          end else if (w_sclk_rise) begin
            r_shift <= w_shift_nxt;
            if (r_cnt != 5'd17) begin
              r_cnt <= r_cnt + 5'd1;
            end
            if (r_cnt == 5'd7 && !w_shift_nxt[7]) begin
              r_tx        <= w_rd_data;
              r_rd_active <= 1'b1;
            end
          end else if (w_sclk_fall && r_rd_active) begin
            r_cipo <= r_tx[7];
            r_tx   <= {r_tx[6:0], 1'b0};
          end
        end
        S_COMMIT: begin
          r_cipo      <= 1'b0;
          r_rd_active <= 1'b0;
          if (r_cnt == 5'd16) begin
            r_frame_valid <= 1'b1;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
              if (r_shift[15] && r_shift[14:8] == 7'(i)) begin
                r_regs[i] <= r_shift[7:0];
              end
            end
          end else begin
            r_frame_err <= 1'b1;
          end
        end
        default: begin
          r_cipo      <= 1'b0;
          r_rd_active <= 1'b0;
        end
      endcase
    end
  end

  assign cipo            = r_cipo;
  assign frame_valid     = r_frame_valid;
  assign frame_err       = r_frame_err;
  assign en_reg_out_7_0  = r_regs[0];
  assign en_reg_out_15_8 = r_regs[1];
  assign en_reg_pwm_7_0  = r_regs[2];
  assign en_reg_pwm_15_8 = r_regs[3];
  assign pwm_duty_cycle  = r_regs[4];

endmodule
